// File: rtl/graph_path_extract_if.sv
// Handshake and data bundle between the path extractor, its upstream search stage,
// the shared edge RAM and the downstream trajectory stage.
interface graph_path_extract_if #(
  parameter int ADDR_W    = 11,
  parameter int POSE_W    = 8,
  parameter int MAX_LEVEL = 10
);
  logic                          start;
  logic [3:0]                    levelCnt;
  logic [POSE_W-1:0]             startPose;
  logic [POSE_W-1:0]             endPose;
  logic [MAX_LEVEL*ADDR_W-1:0]   selectEdge;
  logic [ADDR_W-1:0]             ramAddress;
  logic [2*POSE_W-1:0]           RAMData;
  logic                          poseValid;
  logic [POSE_W-1:0]             poseData;
  logic                          poseLast;
  logic                          poseReady;
  logic                          busy;
  logic                          done;
  logic                          error;
  logic [2:0]                    errCode;

  modport slave (
    input  start, levelCnt, startPose, endPose, selectEdge, RAMData, poseReady,
    output ramAddress, poseValid, poseData, poseLast, busy, done, error, errCode
  );

  modport master (
    output start, levelCnt, startPose, endPose, selectEdge, RAMData, poseReady,
    input  ramAddress, poseValid, poseData, poseLast, busy, done, error, errCode
  );
endinterface

// File: rtl/graph_path_extract.sv
// Walks the edge chain selected by the backward search from startPose to endPose,
// streaming each waypoint pose downstream and flagging broken or inconsistent chains.
module graph_path_extract #(
  parameter int EDGE_NUM  = 1034,
  parameter int POSE_NUM  = 66,
  parameter int MAX_LEVEL = 10,
  parameter int ADDR_W    = 11,
  parameter int POSE_W    = 8
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  graph_path_extract_if.slave   bus
);

  localparam int                 IDX_W    = $clog2(MAX_LEVEL);
  localparam logic [ADDR_W-1:0]  EDGE_LIM = ADDR_W'(EDGE_NUM);
  localparam logic [POSE_W-1:0]  POSE_LIM = POSE_W'(POSE_NUM);
  localparam logic [3:0]         LVL_MAX  = 4'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE, S_EMIT_START, S_READ, S_WAIT, S_CHECK, S_EMIT, S_DONE, S_ERR
  } state_t;

  state_t                       state_q;
  logic [MAX_LEVEL*ADDR_W-1:0]  sel_q;
  logic [POSE_W-1:0]            end_q;
  logic [POSE_W-1:0]            cur_q;
  logic [IDX_W-1:0]             idx_q;
  logic [ADDR_W-1:0]            ram_addr_q;
  logic                         pose_valid_q;
  logic [POSE_W-1:0]            pose_data_q;
  logic                         pose_last_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         error_q;
  logic [2:0]                   err_code_q;

  logic [ADDR_W-1:0]            slot_a [MAX_LEVEL];
  logic [ADDR_W-1:0]            slot_d;
  logic [POSE_W-1:0]            first_d;
  logic [POSE_W-1:0]            second_d;
  logic [POSE_W-1:0]            next_d;
  logic [2:0]                   chk_code_d;
  logic                         hs_d;

  for (genvar k = 0; k < MAX_LEVEL; k++) begin : g_slot
    assign slot_a[k] = sel_q[k*ADDR_W +: ADDR_W];
  end

  assign slot_d   = slot_a[idx_q];
  assign first_d  = bus.RAMData[2*POSE_W-1:POSE_W];
  assign second_d = bus.RAMData[POSE_W-1:0];
  assign hs_d     = pose_valid_q & bus.poseReady;

  // The edge may be stored in either orientation; step to whichever end is not curPose.
  always_comb begin
    next_d     = '0;
    chk_code_d = 3'd0;
    if (first_d == second_d) begin
      chk_code_d = 3'd3;
    end else if (first_d == cur_q) begin
      next_d = second_d;
    end else if (second_d == cur_q) begin
      next_d = first_d;
    end else begin
      chk_code_d = 3'd3;
    end
    if ((chk_code_d == 3'd0) && (next_d >= POSE_LIM)) begin
      chk_code_d = 3'd5;
    end else begin
      chk_code_d = chk_code_d;
    end
  end

  // Extraction FSM with all outputs registered.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      end_q        <= '0;
      cur_q        <= '0;
      idx_q        <= '0;
      ram_addr_q   <= '0;
      pose_valid_q <= 1'b0;
      pose_data_q  <= '0;
      pose_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            sel_q      <= bus.selectEdge;
            end_q      <= bus.endPose;
            error_q    <= 1'b0;
            err_code_q <= 3'd0;
            busy_q     <= 1'b1;
            if ((bus.levelCnt == 4'd0) || (bus.levelCnt > LVL_MAX)) begin
              state_q    <= S_ERR;
              error_q    <= 1'b1;
              err_code_q <= 3'd1;
            end else if ((bus.startPose >= POSE_LIM) || (bus.endPose >= POSE_LIM)) begin
              state_q    <= S_ERR;
              error_q    <= 1'b1;
              err_code_q <= 3'd5;
            end else begin
              cur_q        <= bus.startPose;
              idx_q        <= IDX_W'(bus.levelCnt - 4'd1);
              pose_valid_q <= 1'b1;
              pose_data_q  <= bus.startPose;
              pose_last_q  <= 1'b0;
              state_q      <= S_EMIT_START;
            end
          end
        end
        S_EMIT_START: begin
          if (hs_d) begin
            pose_valid_q <= 1'b0;
            state_q      <= S_READ;
          end
        end
        S_READ: begin
          if (slot_d >= EDGE_LIM) begin
            state_q    <= S_ERR;
            error_q    <= 1'b1;
            err_code_q <= 3'd2;
          end else begin
            ram_addr_q <= slot_d;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (chk_code_d != 3'd0) begin
            state_q    <= S_ERR;
            error_q    <= 1'b1;
            err_code_q <= chk_code_d;
          end else begin
            pose_valid_q <= 1'b1;
            pose_data_q  <= next_d;
            pose_last_q  <= (idx_q == '0);
            state_q      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (hs_d) begin
            pose_valid_q <= 1'b0;
            pose_last_q  <= 1'b0;
            cur_q        <= pose_data_q;
            if (idx_q == '0) begin
              if (pose_data_q == end_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_ERR;
                error_q    <= 1'b1;
                err_code_q <= 3'd4;
              end
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q       <= 1'b0;
          pose_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ramAddress = ram_addr_q;
  assign bus.poseValid  = pose_valid_q;
  assign bus.poseData   = pose_data_q;
  assign bus.poseLast   = pose_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.errCode    = err_code_q;

endmodule

// File: tb/tb_graph_path_extract.sv
// Scoreboard bench for graph_path_extract: directed paths, backpressure, error cases
// and a mid-run reset, with a synchronous edge RAM model.
module tb_graph_path_extract;

  typedef struct {
    logic [7:0]  pose;
    logic        last;
    logic        chk_addr;
    logic [10:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          fails = 0;
  bit          bp_en = 1'b0;
  int          stall_cnt = 0;
  exp_t        exp_q[$];
  logic [15:0] ram [0:2047];

  graph_path_extract_if bus ();

  graph_path_extract dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.RAMData <= ram[bus.ramAddress];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Downstream ready: either always ready, or 5 stalled cycles per waypoint.
  always @(posedge clk) begin
    #1;
    if (!bp_en) begin
      bus.poseReady = 1'b1;
      stall_cnt = 0;
    end else if (bus.poseValid) begin
      if (stall_cnt < 5) begin
        bus.poseReady = 1'b0;
        stall_cnt++;
      end else begin
        bus.poseReady = 1'b1;
        stall_cnt = 0;
      end
    end else begin
      bus.poseReady = 1'b0;
      stall_cnt = 0;
    end
  end

  // Monitor: compare every presented waypoint with the queue head, pop on handshake.
  always @(negedge clk) begin
    if (rst_n && bus.poseValid) begin
      if (exp_q.size() == 0) begin
        if (bus.poseReady) begin
          checks++;
          fails++;
          $display("FAIL unexpected_waypoint: got pose %0d expected none", bus.poseData);
        end
      end else begin
        chk("poseData", 32'(bus.poseData), 32'(exp_q[0].pose));
        chk("poseLast", 32'(bus.poseLast), 32'(exp_q[0].last));
        if (bus.poseReady) begin
          if (exp_q[0].chk_addr) chk("ramAddress", 32'(bus.ramAddress), 32'(exp_q[0].addr));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push(input logic [7:0] p, input logic l, input logic c, input logic [10:0] a);
    exp_t e;
    e.pose = p; e.last = l; e.chk_addr = c; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic push_nominal(input logic [7:0] ep_unused);
    push(8'd5, 1'b0, 1'b0, 11'd0);
    push(8'd3, 1'b0, 1'b1, 11'd100);
    push(8'd7, 1'b0, 1'b1, 11'd12);
    push(8'd9, 1'b1, 1'b1, 11'd40);
  endtask

  task automatic issue(input logic [3:0] lc, input logic [7:0] sp, input logic [7:0] ep,
                       input logic [10:0] s0, input logic [10:0] s1, input logic [10:0] s2);
    logic [109:0] sel;
    sel = '0;
    sel[10:0]  = s0;
    sel[21:11] = s1;
    sel[32:22] = s2;
    @(negedge clk);
    bus.levelCnt   = lc;
    bus.startPose  = sp;
    bus.endPose    = ep;
    bus.selectEdge = sel;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.selectEdge = '1;
    bus.startPose  = 8'hEE;
    bus.endPose    = 8'hEE;
  endtask

  task automatic run(input string nm, input logic [3:0] lc, input logic [7:0] sp,
                     input logic [7:0] ep, input logic [10:0] s0, input logic [10:0] s1,
                     input logic [10:0] s2, input bit exp_done, input logic [2:0] exp_code);
    bit got_done;
    bit ended;
    got_done = 1'b0;
    ended    = 1'b0;
    issue(lc, sp, ep, s0, s1, s2);
    for (int i = 0; i < 400 && !ended; i++) begin
      if (bus.done) got_done = 1'b1;
      if (bus.done || bus.error) ended = 1'b1;
      if (!ended) @(negedge clk);
    end
    if (!ended) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got no done/error expected completion", nm);
    end
    chk({nm, "_done"}, 32'(got_done), 32'(exp_done));
    chk({nm, "_error"}, 32'(bus.error), 32'(exp_code != 3'd0));
    chk({nm, "_errCode"}, 32'(bus.errCode), 32'(exp_code));
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({nm, "_done_after"}, 32'(bus.done), 32'd0);
    chk({nm, "_pending_waypoints"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ramAddress"}, 32'(bus.ramAddress), 32'd0);
    chk({nm, "_poseValid"}, 32'(bus.poseValid), 32'd0);
    chk({nm, "_poseData"}, 32'(bus.poseData), 32'd0);
    chk({nm, "_poseLast"}, 32'(bus.poseLast), 32'd0);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_error"}, 32'(bus.error), 32'd0);
    chk({nm, "_errCode"}, 32'(bus.errCode), 32'd0);
  endtask

  initial begin
    bit seen_hs;
    bit stalled;
    for (int a = 0; a < 2048; a++) ram[a] = 16'h0000;
    ram[100] = 16'h0305;
    ram[12]  = 16'h0703;
    ram[40]  = 16'h0907;
    bus.start      = 1'b0;
    bus.levelCnt   = 4'd0;
    bus.startPose  = 8'd0;
    bus.endPose    = 8'd0;
    bus.selectEdge = '0;
    bus.poseReady  = 1'b1;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_nominal(8'd9);
    run("nominal", 4'd3, 8'd5, 8'd9, 11'd40, 11'd12, 11'd100, 1'b1, 3'd0);

    bp_en = 1'b1;
    push_nominal(8'd9);
    run("backpressure", 4'd3, 8'd5, 8'd9, 11'd40, 11'd12, 11'd100, 1'b1, 3'd0);
    bp_en = 1'b0;

    ram[12] = 16'h0802;
    push(8'd5, 1'b0, 1'b0, 11'd0);
    push(8'd3, 1'b0, 1'b1, 11'd100);
    run("broken", 4'd3, 8'd5, 8'd9, 11'd40, 11'd12, 11'd100, 1'b0, 3'd3);
    ram[12] = 16'h0703;

    run("lvl0", 4'd0, 8'd5, 8'd9, 11'd40, 11'd12, 11'd100, 1'b0, 3'd1);
    run("lvl11", 4'd11, 8'd5, 8'd9, 11'd40, 11'd12, 11'd100, 1'b0, 3'd1);

    push(8'd5, 1'b0, 1'b0, 11'd0);
    run("bad_edge", 4'd1, 8'd5, 8'd9, 11'd1040, 11'd0, 11'd0, 1'b0, 3'd2);

    run("bad_pose", 4'd3, 8'd66, 8'd9, 11'd40, 11'd12, 11'd100, 1'b0, 3'd5);

    push_nominal(8'd8);
    run("wrong_end", 4'd3, 8'd5, 8'd8, 11'd40, 11'd12, 11'd100, 1'b0, 3'd4);

    // Abort during the stall on the second waypoint.
    bp_en = 1'b1;
    push_nominal(8'd9);
    issue(4'd3, 8'd5, 8'd9, 11'd40, 11'd12, 11'd100);
    seen_hs = 1'b0;
    stalled = 1'b0;
    for (int i = 0; i < 200 && !stalled; i++) begin
      @(negedge clk);
      if (seen_hs && bus.poseValid && !bus.poseReady) stalled = 1'b1;
      if (bus.poseValid && bus.poseReady) seen_hs = 1'b1;
    end
    chk("midrun_reached_stall", 32'(stalled), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    exp_q.delete();
    bp_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midrun_held");
    rst_n = 1'b1;
    @(negedge clk);

    push_nominal(8'd9);
    run("after_reset", 4'd3, 8'd5, 8'd9, 11'd40, 11'd12, 11'd100, 1'b1, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
